// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter's upstream (CPU/DMA) and
// downstream (SDRAM) sides.
//   master modport: the side that initiates cycles (drives cyc/stb/...).
//   slave modport : the side that answers (drives ack/err/read data).
interface wb_rr_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin Wishbone arbiter: shares one SDRAM slave port
// between m0 (CPU) and m1 (DMA).
// - Grant FSM (Idle/Gnt0/Gnt1). A grant takes effect the cycle after the request is
//   sampled, and there is always one Idle cycle between grants.
// - Ties go to the master that did not hold the last grant. After reset that is m0.
// - Per-grant beat limit MAX_BURST. It applies only while the other master is requesting.
// - Optional watchdog abort, enabled by defining the macro ARB_TIMEOUT_EN.
//   Without the macro, m0.err and m1.err are tied to 0.
module wb_rr_arbiter #(
    parameter int unsigned MAX_BURST = 8,    // 1..255
    parameter int unsigned TIMEOUT   = 255   // 2..65535, used only with ARB_TIMEOUT_EN
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_rr_arbiter_if.slave         m0,
    wb_rr_arbiter_if.slave         m1,
    wb_rr_arbiter_if.master        s,
    output logic [31:0]            dat_o,
    output logic [1:0]             gnt_o
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [7:0] MaxBurstW = 8'(MAX_BURST);

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 0 = m0, 1 = m1
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic        req0, req1;
    logic        granted;
    logic        granted_cyc;
    logic        other_req;
    logic        pending;
    logic        burst_done;
    logic        release_gnt;
    logic        abort;

    // Requests as seen by the arbiter.
    always_comb begin
        req0 = m0.cyc & m0.stb;
        req1 = m1.cyc & m1.stb;
    end

    // Read data goes to both masters; only the granted one sees an ack.
    always_comb begin
        dat_o    = s.dat_r;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
    end

    // Bus error from the SDRAM side is not part of this arbiter's protocol.
    logic unused_s_err;
    always_comb unused_s_err = s.err;

    // Downstream mux and ack routing. Idle parks address/data on m0 so they stay deterministic.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        m0.ack  = 1'b0;
        m1.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.err  = 1'b0;
        gnt_o   = 2'b00;
        unique case (state_q)
            StGnt0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.sel   = m0.sel;
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
                m0.ack  = s.ack & ~abort;
                m0.err  = abort;
                gnt_o   = 2'b01;
            end
            StGnt1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.sel   = m1.sel;
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
                m1.ack  = s.ack & ~abort;
                m1.err  = abort;
                gnt_o   = 2'b10;
            end
            default: ;
        endcase
    end

    // Release conditions for the current grant.
    always_comb begin
        granted     = (state_q != StIdle);
        granted_cyc = (state_q == StGnt1) ? m1.cyc : m0.cyc;
        other_req   = (state_q == StGnt1) ? req0 : req1;
        // A beat is outstanding while the strobe waits for its ack.
        pending     = s.stb & ~s.ack;
        // Use >= so that a saturated counter also yields at once when the other master arrives late.
        burst_done  = granted & s.ack & other_req &
                      (({1'b0, beat_cnt_q} + 9'd1) >= {1'b0, MaxBurstW});
        release_gnt = granted & ((~granted_cyc & ~pending) | burst_done | abort);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

    logic [15:0] wdog_q, wdog_d;

    // Watchdog: count stalled strobe cycles. It clears on ack, on abort and outside a grant.
    always_comb begin
        wdog_d = '0;
        if (granted && !abort && s.stb && !s.ack) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    always_comb abort = granted & (wdog_q >= TimeoutW);
`else
    logic [15:0] unused_timeout;
    always_comb unused_timeout = 16'(TIMEOUT);
    always_comb abort = 1'b0;
`endif

    // Grant FSM next-state, last-grant tracking and beat counter.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                beat_cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_gnt_q ? StGnt0 : StGnt1;
                end else if (req0) begin
                    state_d = StGnt0;
                end else if (req1) begin
                    state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                if (s.ack && beat_cnt_q != MaxBurstW) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (release_gnt) begin
                    state_d    = StIdle;
                    last_gnt_d = (state_q == StGnt1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers. Reset makes m1 the last grant so that m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
